// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch front end
package if_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } if_state_t;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } skid_entry_t;

endpackage

// File: rtl/if_skid_buffer.sv
// rtl/if_skid_buffer.sv - single-entry skid buffer holding one fetched instruction
import if_pkg::*;

module if_skid_buffer (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               drain_i,
    input  logic               discard_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [31:0]        pc_i,
    output skid_entry_t        entry_o
);

    skid_entry_t entry_q;

    // Load captures a response; drain or discard both empty the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (load_i) begin
            entry_q <= '{valid: 1'b1, instr: instr_i, pc: pc_i};
        end else if (drain_i || discard_i) begin
            entry_q <= '0;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/if_pc_fetch.sv
// rtl/if_pc_fetch.sv - PC register and imem fetch FSM; IF_PC_ALIGN_CHECK_EN enables misalign reporting
import if_pkg::*;

module if_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               stall,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_plus4,
    output logic               flush,
    output logic               misalign
);

    if_state_t          state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        redirect_q, redirect_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pc4_q, pc4_d;
    logic               flush_q;
    logic               skid_load, skid_drain, skid_discard;
    skid_entry_t        skid;
    logic [31:0]        target;

    // Low two bits of a redirect are dropped before they ever reach the PC.
    assign target = branch_target & ~32'h3;

    if_skid_buffer u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (skid_load),
        .drain_i   (skid_drain),
        .discard_i (skid_discard),
        .instr_i   (imem_rdata),
        .pc_i      (addr_q),
        .entry_o   (skid)
    );

    // State, PC and IF/ID output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= RESET_PC;
            redirect_q <= '0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
            pc4_q      <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            redirect_q <= redirect_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            flush_q    <= branch_taken;
        end
    end

    // Next-state logic; a redirect always wins over stall and returning data.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        redirect_d   = redirect_q;
        valid_d      = stall ? valid_q : 1'b0;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pc4_d        = pc4_q;
        imem_req     = 1'b0;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_discard = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (branch_taken) addr_d = target;
            end
            REQ: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    if (imem_ack) begin
                        addr_d = target;
                    end else begin
                        // Address must stay put for the outstanding request.
                        redirect_d = target;
                        state_d    = DRAIN;
                    end
                end else if (imem_ack) begin
                    addr_d = addr_q + PC_STEP;
                    if (!valid_q || !stall) begin
                        valid_d = 1'b1;
                        instr_d = imem_rdata;
                        pc_d    = addr_q;
                        pc4_d   = addr_q + PC_STEP;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    skid_discard = 1'b1;
                    addr_d       = target;
                    state_d      = REQ;
                end else if (!stall) begin
                    skid_drain = 1'b1;
                    valid_d    = 1'b1;
                    instr_d    = skid.instr;
                    pc_d       = skid.pc;
                    pc4_d      = skid.pc + PC_STEP;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (branch_taken) redirect_d = target;
                if (imem_ack) begin
                    addr_d  = branch_taken ? target : redirect_q;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (branch_taken) valid_d = 1'b0;
    end

`ifdef IF_PC_ALIGN_CHECK_EN
    logic misalign_q;

    // Report a redirect whose target was not word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= branch_taken && (branch_target[1:0] != 2'b00);
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign imem_addr   = addr_q;
    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc       = pc_q;
    assign if_pc_plus4 = pc4_q;
    assign flush       = flush_q;

endmodule

// File: tb/tb_if_pc_fetch.sv
// tb/tb_if_pc_fetch.sv - directed vector bench for if_pc_fetch
module tb_if_pc_fetch;

    localparam logic [31:0] KEY = 32'hDEAD_BEEF;
`ifdef IF_PC_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        flush;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int cnt;

    if_pc_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .flush         (flush),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    // Memory model: acks after lat waiting cycles, data is address xor KEY.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (!imem_req || imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end
    assign imem_ack   = imem_req && (cnt >= lat);
    assign imem_rdata = imem_addr ^ KEY;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_mis;
    } vec_t;

    vec_t vt[20];

    initial begin
        // cycle k: outputs expected in cycle k, then inputs applied in cycle k
        vt[0]  = '{0, 0, 32'h0,         0, 32'h100,       0, 32'h0,         0, 0};
        vt[1]  = '{0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         0, 0};
        vt[2]  = '{0, 0, 32'h0,         1, 32'h104,       1, 32'h100,       0, 0};
        vt[3]  = '{1, 0, 32'h0,         1, 32'h108,       1, 32'h104,       0, 0};
        vt[4]  = '{1, 0, 32'h0,         0, 32'h10C,       1, 32'h104,       0, 0};
        vt[5]  = '{1, 0, 32'h0,         0, 32'h10C,       1, 32'h104,       0, 0};
        vt[6]  = '{0, 0, 32'h0,         0, 32'h10C,       1, 32'h104,       0, 0};
        vt[7]  = '{0, 0, 32'h0,         1, 32'h10C,       1, 32'h108,       0, 0};
        vt[8]  = '{0, 1, 32'h40,        1, 32'h110,       1, 32'h10C,       0, 0};
        vt[9]  = '{0, 0, 32'h0,         1, 32'h40,        0, 32'h0,         1, 0};
        vt[10] = '{0, 0, 32'h0,         1, 32'h44,        1, 32'h40,        0, 0};
        vt[11] = '{0, 1, 32'h43,        1, 32'h48,        1, 32'h44,        0, 0};
        vt[12] = '{0, 0, 32'h0,         1, 32'h40,        0, 32'h0,         1, 1};
        vt[13] = '{0, 1, 32'hFFFF_FFFC, 1, 32'h44,        1, 32'h40,        0, 0};
        vt[14] = '{0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         1, 0};
        vt[15] = '{0, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC, 0, 0};
        vt[16] = '{1, 0, 32'h0,         1, 32'h4,         1, 32'h0,         0, 0};
        vt[17] = '{1, 1, 32'h80,        0, 32'h8,         1, 32'h0,         0, 0};
        vt[18] = '{0, 0, 32'h0,         1, 32'h80,        0, 32'h0,         1, 0};
        vt[19] = '{0, 0, 32'h0,         1, 32'h84,        1, 32'h80,        0, 0};

        rst_n = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        stall = 1'b0;
        lat = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_pc4", if_pc_plus4, 32'h0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_mis", {31'b0, misalign}, 32'd0);

        // Release just after edge 0, so cycle 0 is spent in IDLE.
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("v%0d_req", k), {31'b0, imem_req}, {31'b0, vt[k].e_req});
            chk($sformatf("v%0d_addr", k), imem_addr, vt[k].e_addr);
            chk($sformatf("v%0d_valid", k), {31'b0, if_valid}, {31'b0, vt[k].e_valid});
            chk($sformatf("v%0d_flush", k), {31'b0, flush}, {31'b0, vt[k].e_flush});
            chk($sformatf("v%0d_mis", k), {31'b0, misalign}, {31'b0, vt[k].e_mis & ALIGN_EN});
            if (vt[k].e_valid) begin
                chk($sformatf("v%0d_pc", k), if_pc, vt[k].e_pc);
                chk($sformatf("v%0d_pc4", k), if_pc_plus4, vt[k].e_pc + 32'd4);
                chk($sformatf("v%0d_instr", k), if_instr, vt[k].e_pc ^ KEY);
            end
            stall         = vt[k].stall;
            branch_taken  = vt[k].br;
            branch_target = vt[k].tgt;
        end

        // Slow memory: redirect in the first cycle of an outstanding request.
        @(posedge clk);
        #1 rst_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        lat = 3;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("lat_c0_req", {31'b0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_c1_req", {31'b0, imem_req}, 32'd1);
        chk("lat_c1_addr", imem_addr, 32'h100);
        chk("lat_c1_ack", {31'b0, imem_ack}, 32'd0);
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        chk("lat_flush", {31'b0, flush}, 32'd1);
        for (int i = 0; i < 10 && !imem_ack; i++) begin
            chk($sformatf("lat_hold%0d", i), imem_addr, 32'h100);
            @(posedge clk);
            #1;
        end
        chk("lat_ack_seen", {31'b0, imem_ack}, 32'd1);
        chk("lat_ack_addr", imem_addr, 32'h100);
        @(posedge clk);
        #1;
        chk("lat_discard", {31'b0, if_valid}, 32'd0);
        chk("lat_newaddr", imem_addr, 32'h200);
        chk("lat_newreq", {31'b0, imem_req}, 32'd1);
        for (int i = 0; i < 10 && !if_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("lat_valid", {31'b0, if_valid}, 32'd1);
        chk("lat_pc", if_pc, 32'h200);
        chk("lat_instr", if_instr, 32'h200 ^ KEY);

        // Reset in the middle of an outstanding request.
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'b0, if_valid}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h100);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("mid_c0_req", {31'b0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_c1_req", {31'b0, imem_req}, 32'd1);
        chk("mid_c1_addr", imem_addr, 32'h100);
        chk("mid_c1_valid", {31'b0, if_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_pc_fetch.md
# if_pc_fetch

Instruction-fetch stage front end of the MIPS pipeline. Holds the program counter, issues word requests to instruction memory over a req/ack handshake, and presents the fetched instruction with its PC and PC+4 to the IF/ID register. It consumes the branch redirect produced downstream: the branch target computed in EX as PC+4 + (offset << 2), carried through EX/MEM, together with the resolved branch-taken bit. The PC+4 it emits becomes the PC input of that EX target calculation.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  pipeline clock; all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low; one clock domain only
- branch_taken  in  1  redirect request from MEM stage
- branch_target  in  32  redirect address from EX/MEM
- stall  in  1  hazard unit holds the IF/ID register
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; word aligned
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- if_valid  out  1  if_instr/if_pc/if_pc_plus4 hold a live instruction
- if_instr  out  32  fetched instruction
- if_pc  out  32  address of if_instr
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32
- flush  out  1  one-cycle pulse: kill younger IF/ID contents
- misalign  out  1  one-cycle pulse: redirect target had bits [1:0] ≠ 0

## Operation
- State register values: IDLE, REQ, HOLD, DRAIN. addr_q drives imem_addr. A one-entry skid buffer (valid, instr, pc) absorbs a response that arrives while the output is stalled.
- Reset: state IDLE; addr_q = RESET_PC; all outputs 0; skid empty.
- IDLE: imem_req=0. Next cycle goes to REQ. A branch_taken in IDLE loads addr_q=target.
- REQ: imem_req=1. addr_q is held stable until imem_ack.
  - ack, no branch, output free (!if_valid || !stall): load the output from the response. addr_q += 4. Stay in REQ, giving back-to-back fetch.
  - ack, no branch, output stalled: load the skid buffer. addr_q += 4. Go to HOLD.
  - ack and branch: discard the response. addr_q = target. Stay in REQ.
  - branch without ack: addr_q must stay stable for the outstanding request, so latch the target in redirect_q and go to DRAIN.
- HOLD: imem_req=0.
  - !stall: move the skid buffer to the output and go to REQ.
  - branch: discard the skid buffer. addr_q = target. Go to REQ.
- DRAIN: imem_req=1 with the old address. On ack, discard the data, load addr_q = redirect_q, and go to REQ. A further branch in DRAIN overwrites redirect_q.
- Any branch_taken, in any state: if_valid = 0 and flush = 1 on the next cycle. branch_taken has priority over stall and over ack data.
- When stall is high and no branch is present, the output registers hold their values.
- Target low bits [1:0] are always forced to 0 before use.
- Arithmetic is 32-bit unsigned and wraps: addr 0xFFFF_FFFC advances to 0x0000_0000.
- Reset asserted mid-request: return immediately to the reset state. An outstanding ack after reset release is ignored, because IDLE does not sample ack.

## Timing
- Reset release at edge 0: IDLE during cycle 0. imem_req=1 with addr RESET_PC in cycle 1.
- Zero-wait memory (ack in the same cycle as req): if_valid rises at cycle 2, then one instruction per cycle.
- branch_taken at cycle t with no request outstanding: flush=1 and if_valid=0 at t+1. Request at the target in t+1. Target instruction valid at t+2.
- With an outstanding request, the redirect adds the remaining memory latency (DRAIN).
- At most one fetch is issued beyond a stall; that fetch is held in the skid buffer.

## Configuration
- IF_PC_ALIGN_CHECK_EN defined: misalign pulses for one cycle, at t+1, when branch_target[1:0] ≠ 0 at the branch_taken cycle. Fetch still uses the forced-aligned target.
- IF_PC_ALIGN_CHECK_EN undefined: misalign is tied to 0, no detection logic is built, and alignment is forced silently.

## Structure
- Shared package if_pkg holds:
  - the state enum if_state_t;
  - INSTR_W=32 and PC_STEP=4;
  - the skid entry struct (valid, instr, pc).
- One sub-module, if_skid_buffer: single entry with load, drain and discard.

## Test plan
- Reset release with RESET_PC=0x100 and zero-wait memory: imem_addr sequence 0x100, 0x104, 0x108. if_pc_plus4 = 0x104 when if_pc = 0x100.
- stall high for 3 cycles during back-to-back fetch: one extra fetch goes to the skid buffer and imem_req drops. When stall falls, the next if_pc = previous + 4, with no instruction lost or duplicated.
- branch_taken with target 0x40 while fetching 0x20: flush pulses for 1 cycle, if_valid=0 for one cycle, the next valid if_pc = 0x40.
- Memory with 3-cycle ack latency, branch to 0x200 in the request's first cycle: imem_addr stays at the old value until ack, that data is discarded, then a request to 0x200 follows.
- Simultaneous stall and branch to 0x80 in HOLD: the skid entry is discarded and the next valid if_pc = 0x80. Addr 0xFFFF_FFFC wraps to 0x0.
- With IF_PC_ALIGN_CHECK_EN, target 0x43: misalign pulses once and the fetch goes to 0x40. Without the macro, misalign stays 0.
